// File: rtl/bypass_seq_ctr_if.sv
// -----------------------------------------------------------------------------
// bypass_seq_ctr_if
//
// Purpose:
//   Bundles the run-control and status signals of the sequenced bit-bypass
//   counter so that the counter and its controller connect through a single
//   port.
//
// Parameters:
//   WIDTH   counter width in bits (must match the counter instance)
//
// Signals:
//   start    controller -> counter  begin a run (honoured only while idle)
//   bp       controller -> counter  bypass mask, latched on accepted start
//   en       controller -> counter  advance one step (honoured only while running)
//   abort    controller -> counter  early-terminate the run
//   busy     counter -> controller  a run is in progress
//   cnt_out  counter -> controller  current code (optionally bit-reversed)
//   ovf      counter -> controller  combinational wrap indicator
//   done     counter -> controller  one-cycle pulse: a pass wrapped
//   aborted  counter -> controller  one-cycle pulse: a run was aborted
//   steps    counter -> controller  advances in the current/most recent pass
//
// Modports:
//   master   the controller side (drives start/bp/en/abort)
//   slave    the counter side
// -----------------------------------------------------------------------------
interface bypass_seq_ctr_if #(
  parameter int WIDTH = 8
) ();

  logic             start;
  logic [WIDTH-1:0] bp;
  logic             en;
  logic             abort;
  logic             busy;
  logic [WIDTH-1:0] cnt_out;
  logic             ovf;
  logic             done;
  logic             aborted;
  logic [WIDTH:0]   steps;

  modport master (
    output start,
    output bp,
    output en,
    output abort,
    input  busy,
    input  cnt_out,
    input  ovf,
    input  done,
    input  aborted,
    input  steps
  );

  modport slave (
    input  start,
    input  bp,
    input  en,
    input  abort,
    output busy,
    output cnt_out,
    output ovf,
    output done,
    output aborted,
    output steps
  );

endinterface : bypass_seq_ctr_if

// File: rtl/bypass_seq_ctr.sv
// -----------------------------------------------------------------------------
// bypass_seq_ctr
//
// Purpose:
//   Sequenced bit-bypass counter for early-terminating stochastic-computing
//   stream generation. A bypass mask latched at start freezes selected counter
//   bits at 0; carries ripple straight through them so only the unmasked bits
//   count. One pass visits every code whose masked bits are 0, in ascending
//   order (2^k codes, k = number of clear mask bits), then reports completion.
//   Run control (start/abort), a step counter and an optional continuous mode
//   sit on top of the basic counter.
//
// Parameters:
//   WIDTH       counter width in bits, minimum 1
//   CONTINUOUS  0: return to idle after a pass wraps
//               1: keep sweeping after each wrap until aborted
//
// Ports:
//   clk     rising-edge clock
//   rst_n   asynchronous active-low reset
//   bus     bypass_seq_ctr_if.slave (start, bp, en, abort in;
//           busy, cnt_out, ovf, done, aborted, steps out)
//
// Compile-time option:
//   BPSEQ_BITREV_EN  when defined, cnt_out presents the counter bit-reversed
//                    (van der Corput order). Internal counting, ovf and steps
//                    are unaffected.
// -----------------------------------------------------------------------------
module bypass_seq_ctr #(
  parameter int WIDTH      = 8,
  parameter bit CONTINUOUS = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  bypass_seq_ctr_if.slave  bus
);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  localparam logic [WIDTH:0] STEP_ONE = {{WIDTH{1'b0}}, 1'b1};

  state_t           state_r;
  state_t           state_s;
  logic [WIDTH-1:0] cnt_r;
  logic [WIDTH-1:0] cnt_s;
  logic [WIDTH-1:0] bp_r;
  logic [WIDTH-1:0] bp_s;
  logic [WIDTH:0]   steps_r;
  logic [WIDTH:0]   steps_s;
  logic             done_r;
  logic             done_s;
  logic             aborted_r;
  logic             aborted_s;

  logic [WIDTH:0]   carry_s;
  logic [WIDTH-1:0] inc_s;
  logic             last_s;
  logic             run_s;

  // Reverse the bit order of a counter code (LSB becomes MSB).
  function automatic logic [WIDTH-1:0] bit_rev(input logic [WIDTH-1:0] v);
    logic [WIDTH-1:0] r;
    r = '0;
    for (int i = 0; i < WIDTH; i++) begin
      r[i] = v[WIDTH-1-i];
    end
    return r;
  endfunction

  // Masked carry chain: a masked bit behaves as a permanent 1 for carry
  // propagation, so the carry skips over it, while the XOR is gated by ~bp
  // so the bit itself never toggles.
  always_comb begin
    carry_s    = '0;
    carry_s[0] = 1'b1;
    for (int i = 0; i < WIDTH; i++) begin
      carry_s[i+1] = carry_s[i] & (cnt_r[i] | bp_r[i]);
    end
    inc_s = cnt_r ^ (carry_s[WIDTH-1:0] & ~bp_r);
  end

  // The carry out of the top bit is exactly &(cnt | bp): the final code of
  // the pass, where the next advance must wrap to 0.
  assign last_s = carry_s[WIDTH];
  assign run_s  = (state_r == ST_RUN);

  // Next-state and next-register logic; everything holds unless a rule fires.
  always_comb begin
    state_s   = state_r;
    cnt_s     = cnt_r;
    bp_s      = bp_r;
    steps_s   = steps_r;
    done_s    = 1'b0;
    aborted_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (bus.start) begin
          bp_s    = bus.bp;
          cnt_s   = '0;
          steps_s = '0;
          state_s = ST_RUN;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (bus.abort) begin
          // Abort wins over en; counter and step count freeze for inspection.
          aborted_s = 1'b1;
          state_s   = ST_IDLE;
        end else if (bus.en) begin
          if (!last_s) begin
            cnt_s   = inc_s;
            steps_s = steps_r + STEP_ONE;
          end else begin
            cnt_s  = '0;
            done_s = 1'b1;
            if (CONTINUOUS) begin
              // Restart the pass count so steps tracks the pass in progress.
              steps_s = '0;
              state_s = ST_RUN;
            end else begin
              // One-shot: keep the full pass length visible while idle.
              steps_s = steps_r + STEP_ONE;
              state_s = ST_IDLE;
            end
          end
        end else begin
          state_s = ST_RUN;
        end
      end
      default: begin
        state_s   = ST_IDLE;
        cnt_s     = '0;
        bp_s      = '0;
        steps_s   = '0;
      end
    endcase
  end

  // State and datapath registers with asynchronous reset to an idle, zeroed
  // counter; a reset never produces a done or aborted pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= ST_IDLE;
      cnt_r     <= '0;
      bp_r      <= '0;
      steps_r   <= '0;
      done_r    <= 1'b0;
      aborted_r <= 1'b0;
    end else begin
      state_r   <= state_s;
      cnt_r     <= cnt_s;
      bp_r      <= bp_s;
      steps_r   <= steps_s;
      done_r    <= done_s;
      aborted_r <= aborted_s;
    end
  end

  assign bus.busy    = run_s;
  assign bus.steps   = steps_r;
  assign bus.done    = done_r;
  assign bus.aborted = aborted_r;
  // Wrap indicator in the same cycle as the wrapping en; suppressed on abort
  // because abort pre-empts the advance.
  assign bus.ovf     = run_s & bus.en & ~bus.abort & last_s;

`ifdef BPSEQ_BITREV_EN
  assign bus.cnt_out = bit_rev(cnt_r);
`else
  assign bus.cnt_out = cnt_r;
`endif

endmodule : bypass_seq_ctr

// File: tb/tb_bypass_seq_ctr.sv
// -----------------------------------------------------------------------------
// tb_bypass_seq_ctr
//
// Drives a one-shot (dut0) and a continuous (dut1) counter, both WIDTH = 4,
// with identical stimulus. A reference model enumerates the legal codes of a
// mask (values with no masked bit set) in ascending order and steps through
// them; every cycle all outputs of both counters are compared with the model.
// Directed sequences cover the scenarios with explicit constant expectations,
// followed by randomized stimulus.
// -----------------------------------------------------------------------------
module tb_bypass_seq_ctr;

  localparam int W = 4;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  bypass_seq_ctr_if #(.WIDTH(W)) bus0 ();
  bypass_seq_ctr_if #(.WIDTH(W)) bus1 ();

  bypass_seq_ctr #(.WIDTH(W), .CONTINUOUS(1'b0)) dut0 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus0.slave)
  );

  bypass_seq_ctr #(.WIDTH(W), .CONTINUOUS(1'b1)) dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus1.slave)
  );

  int n_checks = 0;
  int n_errors = 0;

  // reference model state, index 0 = one-shot, 1 = continuous
  bit         m_run   [2];
  logic [3:0] m_cnt   [2];
  logic [3:0] m_bp    [2];
  logic [4:0] m_steps [2];
  bit         m_done  [2];
  bit         m_abt   [2];

  logic ovf0_seen;
  logic ovf1_seen;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // next legal code above c for mask b: {valid, code}; valid = 0 means c is last
  function automatic logic [4:0] next_code(input logic [3:0] c, input logic [3:0] b);
    int v;
    logic [3:0] vv;
    for (v = int'(c) + 1; v < 16; v++) begin
      vv = 4'(v);
      if ((vv & b) == 4'b0000) return {1'b1, vv};
    end
    return 5'b00000;
  endfunction

  function automatic logic [3:0] out_code(input logic [3:0] c);
`ifdef BPSEQ_BITREV_EN
    return {c[0], c[1], c[2], c[3]};
`else
    return c;
`endif
  endfunction

  task automatic model_reset();
    for (int m = 0; m < 2; m++) begin
      m_run[m] = 1'b0; m_cnt[m] = 4'd0; m_bp[m] = 4'd0;
      m_steps[m] = 5'd0; m_done[m] = 1'b0; m_abt[m] = 1'b0;
    end
  endtask

  task automatic model_edge(input logic s, input logic [3:0] b, input logic e, input logic a);
    logic [4:0] nx;
    for (int m = 0; m < 2; m++) begin
      m_done[m] = 1'b0;
      m_abt[m]  = 1'b0;
      if (!m_run[m]) begin
        if (s) begin
          m_run[m] = 1'b1; m_bp[m] = b; m_cnt[m] = 4'd0; m_steps[m] = 5'd0;
        end
      end else if (a) begin
        m_run[m] = 1'b0;
        m_abt[m] = 1'b1;
      end else if (e) begin
        nx = next_code(m_cnt[m], m_bp[m]);
        if (nx[4]) begin
          m_cnt[m]   = nx[3:0];
          m_steps[m] = m_steps[m] + 5'd1;
        end else begin
          m_cnt[m]  = 4'd0;
          m_done[m] = 1'b1;
          if (m == 1) begin
            m_steps[m] = 5'd0;
          end else begin
            m_steps[m] = m_steps[m] + 5'd1;
            m_run[m]   = 1'b0;
          end
        end
      end
    end
  endtask

  task automatic compare_all(input logic e, input logic a);
    logic [4:0] nx0, nx1;
    nx0 = next_code(m_cnt[0], m_bp[0]);
    nx1 = next_code(m_cnt[1], m_bp[1]);
    check_val("d0_busy",    bus0.busy,    m_run[0]);
    check_val("d0_cnt_out", bus0.cnt_out, out_code(m_cnt[0]));
    check_val("d0_steps",   bus0.steps,   m_steps[0]);
    check_val("d0_done",    bus0.done,    m_done[0]);
    check_val("d0_aborted", bus0.aborted, m_abt[0]);
    check_val("d0_ovf",     bus0.ovf,     m_run[0] & e & ~a & ~nx0[4]);
    check_val("d1_busy",    bus1.busy,    m_run[1]);
    check_val("d1_cnt_out", bus1.cnt_out, out_code(m_cnt[1]));
    check_val("d1_steps",   bus1.steps,   m_steps[1]);
    check_val("d1_done",    bus1.done,    m_done[1]);
    check_val("d1_aborted", bus1.aborted, m_abt[1]);
    check_val("d1_ovf",     bus1.ovf,     m_run[1] & e & ~a & ~nx1[4]);
  endtask

  // one clock cycle: drive at negedge, check, clock, update model
  task automatic step(input logic s, input logic [3:0] b, input logic e, input logic a);
    bus0.start = s; bus0.bp = b; bus0.en = e; bus0.abort = a;
    bus1.start = s; bus1.bp = b; bus1.en = e; bus1.abort = a;
    #1;
    compare_all(e, a);
    ovf0_seen = bus0.ovf;
    ovf1_seen = bus1.ovf;
    @(posedge clk);
    model_edge(s, b, e, a);
    @(negedge clk);
  endtask

  logic [3:0] seq_masked [4];
  logic [4:0] seq_cont   [10];

  initial begin
    seq_masked = '{4'd0, 4'd2, 4'd8, 4'd10};
    seq_cont   = '{5'd1, 5'd2, 5'd3, 5'd0, 5'd1, 5'd2, 5'd3, 5'd0, 5'd1, 5'd2};
    rst_n = 1'b0;
    bus0.start = 1'b0; bus0.bp = 4'd0; bus0.en = 1'b0; bus0.abort = 1'b0;
    bus1.start = 1'b0; bus1.bp = 4'd0; bus1.en = 1'b0; bus1.abort = 1'b0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    compare_all(1'b0, 1'b0);
    rst_n = 1'b1;

    // reset mid-run
    step(1'b1, 4'b0000, 1'b0, 1'b0);
    step(1'b0, 4'b0000, 1'b1, 1'b0);
    step(1'b0, 4'b0000, 1'b1, 1'b0);
    step(1'b0, 4'b0000, 1'b1, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    check_val("rst_busy",    bus0.busy,    1'b0);
    check_val("rst_cnt_out", bus0.cnt_out, 4'd0);
    check_val("rst_steps",   bus0.steps,   5'd0);
    check_val("rst_done",    bus0.done,    1'b0);
    check_val("rst_aborted", bus0.aborted, 1'b0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b0, 4'b0000, 1'b0, 1'b0);
    step(1'b0, 4'b0000, 1'b0, 1'b0);

    // masked one-shot, bp = 0101
    step(1'b1, 4'b0101, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      check_val("mask_cnt", bus0.cnt_out, out_code(seq_masked[i]));
      check_val("mask_busy", bus0.busy, 1'b1);
      step(1'b0, 4'b0000, 1'b1, 1'b0);
      check_val("mask_ovf", ovf0_seen, (i == 3));
    end
    check_val("mask_done",  bus0.done,    1'b1);
    check_val("mask_zero",  bus0.cnt_out, 4'd0);
    check_val("mask_idle",  bus0.busy,    1'b0);
    check_val("mask_steps", bus0.steps,   5'd4);
    step(1'b0, 4'b0000, 1'b0, 1'b1);  // stop dut1
    step(1'b0, 4'b0000, 1'b0, 1'b0);

    // all-ones mask: one-step pass
    step(1'b1, 4'b1111, 1'b1, 1'b0);
    step(1'b0, 4'b0000, 1'b1, 1'b0);
    check_val("ones_ovf",   ovf0_seen,  1'b1);
    check_val("ones_done",  bus0.done,  1'b1);
    check_val("ones_steps", bus0.steps, 5'd1);
    step(1'b0, 4'b0000, 1'b0, 1'b1);

    // gapped enable then abort together with en
    step(1'b1, 4'b0000, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 4'b0000, (i % 2) == 0, 1'b0);
    end
    step(1'b0, 4'b0000, 1'b1, 1'b1);
    check_val("abt_ovf",     ovf0_seen,    1'b0);
    check_val("abt_pulse",   bus0.aborted, 1'b1);
    check_val("abt_cnt",     bus0.cnt_out, out_code(4'd5));
    check_val("abt_steps",   bus0.steps,   5'd5);
    check_val("abt_busy",    bus0.busy,    1'b0);

    // continuous mode on dut1, bp = 1100
    step(1'b1, 4'b1100, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 4'b0000, 1'b1, 1'b0);
      check_val("cont_steps", bus1.steps, seq_cont[i]);
      check_val("cont_busy",  bus1.busy,  1'b1);
      check_val("cont_done",  bus1.done,  (i == 3) || (i == 7));
    end
    step(1'b0, 4'b0000, 1'b0, 1'b1);

    // bit reversal: two advances from 0 with no mask
    step(1'b1, 4'b0000, 1'b0, 1'b0);
    step(1'b0, 4'b0000, 1'b1, 1'b0);
    step(1'b0, 4'b0000, 1'b1, 1'b0);
`ifdef BPSEQ_BITREV_EN
    check_val("bitrev_out", bus0.cnt_out, 4'b0100);
`else
    check_val("bitrev_out", bus0.cnt_out, 4'b0010);
`endif
    step(1'b0, 4'b0000, 1'b0, 1'b1);

    // randomized stimulus
    for (int i = 0; i < 600; i++) begin
      step(($urandom_range(0, 3) == 0),
           4'($urandom_range(0, 15)),
           ($urandom_range(0, 3) != 0),
           ($urandom_range(0, 31) == 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule : tb_bypass_seq_ctr
